// File: rtl/lfsr_crc_checker.sv
// Serial CRC checker: accumulates a message through a Galois-style LFSR, then
// compares the LFSR contents bit-serially against a received CRC field.
module lfsr_crc_checker #(
   parameter int                    LFSR_WIDTH = 8,
   parameter logic [LFSR_WIDTH-1:0] SEED       = 8'hD8,
   parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'h44
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DATA,
   input  logic       ACTIVE,
   input  logic       CRC,
   input  logic       valid,
   output logic       done,
   output logic       crc_ok,
   output logic       crc_err,
   output logic [7:0] err_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   localparam logic [LFSR_WIDTH-1:0] LAST_BIT = LFSR_WIDTH'(LFSR_WIDTH - 1);
   // Stage W-1 always takes the feedback bit; lower stages only where TAPS is set.
   localparam logic [LFSR_WIDTH-1:0] FB_MASK  = {1'b1, TAPS[LFSR_WIDTH-2:0]};

   logic [1:0]            state_q, state_d;
   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [LFSR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  mis_q, mis_d;
   logic                  do_chk, chk_mis;
   logic                  fin, fin_err;

   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur,
                                                      input logic                  din);
      logic fb;
      fb = cur[0] ^ din;
      return (cur >> 1) ^ ({LFSR_WIDTH{fb}} & FB_MASK);
   endfunction

   assign chk_mis = mis_q | (CRC ^ lfsr_q[0]);

   // Every path back to IDLE reloads SEED, so in IDLE lfsr_q always holds SEED
   // and both a new message and a zero-length frame start from it.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      do_chk  = 1'b0;
      fin     = 1'b0;
      fin_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (ACTIVE) begin
               lfsr_d  = lfsr_step(lfsr_q, DATA);
               state_d = ACCUM;
            end else if (valid) begin
               do_chk = 1'b1;
            end
         end
         ACCUM: begin
            if (ACTIVE) begin
               lfsr_d = lfsr_step(lfsr_q, DATA);
            end else begin
               state_d = CHECK;
               do_chk  = valid;
            end
         end
         CHECK: begin
            if (ACTIVE) begin
               // Abort: the new frame's first bit is taken this very cycle.
               fin     = 1'b1;
               fin_err = 1'b1;
               lfsr_d  = lfsr_step(SEED, DATA);
               cnt_d   = '0;
               mis_d   = 1'b0;
               state_d = ACCUM;
            end else if (valid) begin
               do_chk = 1'b1;
            end else if (cnt_q != '0) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               lfsr_d  = SEED;
               cnt_d   = '0;
               mis_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            lfsr_d  = SEED;
            cnt_d   = '0;
            mis_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      if (do_chk) begin
         if (cnt_q == LAST_BIT) begin
            fin     = 1'b1;
            fin_err = chk_mis;
            lfsr_d  = SEED;
            cnt_d   = '0;
            mis_d   = 1'b0;
            state_d = IDLE;
         end else begin
            lfsr_d  = lfsr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            mis_d   = chk_mis;
            state_d = CHECK;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         done    <= 1'b0;
         crc_ok  <= 1'b0;
         crc_err <= 1'b0;
         err_cnt <= 8'h00;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
         done    <= fin;
         if (fin) begin
            crc_ok  <= ~fin_err;
            crc_err <= fin_err;
            if (fin_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_crc_checker.sv
// Directed bench for lfsr_crc_checker: default-seed instance plus a SEED=0 instance
// sharing the same serial inputs.
module tb_lfsr_crc_checker;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       DATA = 1'b0, ACTIVE = 1'b0, CRC = 1'b0, valid = 1'b0;
   logic       done, crc_ok, crc_err;
   logic [7:0] err_cnt;
   logic       z_done, z_ok, z_err;
   logic [7:0] z_cnt;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] msg, exp_crc;

   always #5 CLK = ~CLK;

   lfsr_crc_checker dut (
      .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE), .CRC(CRC), .valid(valid),
      .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .err_cnt(err_cnt)
   );

   lfsr_crc_checker #(.LFSR_WIDTH(8), .SEED(8'h00), .TAPS(8'h44)) dut_z (
      .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE), .CRC(CRC), .valid(valid),
      .done(z_done), .crc_ok(z_ok), .crc_err(z_err), .err_cnt(z_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_msg(input logic [7:0] m, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ACTIVE = 1'b1;
         DATA   = m[i];
         tick();
      end
      ACTIVE = 1'b0;
      DATA   = 1'b0;
   endtask

   task automatic send_crc(input logic [7:0] c, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         valid = 1'b1;
         CRC   = c[i];
         tick();
      end
      valid = 1'b0;
      CRC   = 1'b0;
   endtask

   // Straight transcription of the per-stage recurrence, seed 8'hD8, taps 8'h44.
   function automatic logic [7:0] ref_crc(input logic [7:0] m);
      logic [7:0] l, nl, taps;
      logic       fb;
      l    = 8'hD8;
      taps = 8'h44;
      for (int i = 0; i < 8; i++) begin
         fb = l[0] ^ m[i];
         for (int j = 0; j < 7; j++) nl[j] = l[j+1] ^ (taps[j] & fb);
         nl[7] = fb;
         l = nl;
      end
      return l;
   endfunction

   initial begin
      // Reset state
      #2;
      chk("rst_done", done, 1'b0);
      chk("rst_ok", crc_ok, 1'b0);
      chk("rst_err", crc_err, 1'b0);
      chk("rst_cnt", err_cnt, 8'h00);
      tick();
      RST = 1'b1;

      // Zero-length frame against SEED
      send_crc(8'hD8, 8);
      chk("zl_done", done, 1'b1);
      chk("zl_ok", crc_ok, 1'b1);
      chk("zl_err", crc_err, 1'b0);
      chk("zl_cnt", err_cnt, 8'h00);
      tick();
      chk("zl_pulse", done, 1'b0);
      chk("zl_hold", crc_ok, 1'b1);

      // Same frame with bit 3 flipped
      send_crc(8'hD0, 8);
      chk("zlbad_done", done, 1'b1);
      chk("zlbad_err", crc_err, 1'b1);
      chk("zlbad_ok", crc_ok, 1'b0);
      chk("zlbad_cnt", err_cnt, 8'h01);

      // Hand-computed messages: 8'h00 -> 8'h14, 8'h01 -> 8'hBF (SEED D8)
      tick();
      send_msg(8'h00, 8);
      send_crc(8'h14, 8);
      chk("m00_done", done, 1'b1);
      chk("m00_ok", crc_ok, 1'b1);
      send_msg(8'h01, 8);
      send_crc(8'hBF, 8);
      chk("m01_done", done, 1'b1);
      chk("m01_ok", crc_ok, 1'b1);
      chk("m01_cnt", err_cnt, 8'h01);

      // SEED=0 instance: all-zero message leaves the LFSR at zero
      RST = 1'b0;
      tick();
      RST = 1'b1;
      send_msg(8'h00, 8);
      send_crc(8'h00, 8);
      chk("z_done", z_done, 1'b1);
      chk("z_ok", z_ok, 1'b1);
      send_msg(8'h00, 8);
      send_crc(8'h01, 8);
      chk("z_bad_done", z_done, 1'b1);
      chk("z_bad_err", z_err, 1'b1);
      chk("z_bad_cnt", z_cnt, 8'h01);

      // Truncation: valid only for 5 bits
      RST = 1'b0;
      tick();
      RST = 1'b1;
      send_msg(8'h00, 8);
      send_crc(8'h14, 5);
      chk("trunc_nodone", done, 1'b0);
      tick();
      chk("trunc_done", done, 1'b1);
      chk("trunc_err", crc_err, 1'b1);
      chk("trunc_cnt", err_cnt, 8'h01);

      // Reset pulse during the 4th CHECK bit
      tick();
      send_msg(8'h00, 8);
      send_crc(8'h14, 3);
      valid = 1'b1;
      CRC   = 1'b0;
      #2;
      RST = 1'b0;
      #1;
      chk("mrst_done", done, 1'b0);
      chk("mrst_ok", crc_ok, 1'b0);
      chk("mrst_err", crc_err, 1'b0);
      chk("mrst_cnt", err_cnt, 8'h00);
      tick();
      valid = 1'b0;
      RST   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mrst_quiet", done, 1'b0);
      end
      send_msg(8'h01, 8);
      send_crc(8'hBF, 8);
      chk("mrst_good_done", done, 1'b1);
      chk("mrst_good_ok", crc_ok, 1'b1);

      // ACTIVE during CHECK aborts; the interrupting frame still checks clean
      send_msg(8'h00, 8);
      send_crc(8'h14, 3);
      ACTIVE = 1'b1;
      DATA   = 1'b1;
      tick();
      chk("abort_done", done, 1'b1);
      chk("abort_err", crc_err, 1'b1);
      chk("abort_cnt", err_cnt, 8'h01);
      send_msg(8'h00, 7);
      send_crc(8'hBF, 8);
      chk("abort_next_done", done, 1'b1);
      chk("abort_next_ok", crc_ok, 1'b1);

      // Random messages back to back; odd frames keep valid high during ACCUM
      for (int k = 0; k < 10; k++) begin
         msg     = 8'($urandom);
         exp_crc = ref_crc(msg);
         if (k % 2 == 1) valid = 1'b1;
         send_msg(msg, 8);
         send_crc(exp_crc, 8);
         chk("rnd_done", done, 1'b1);
         chk("rnd_ok", crc_ok, 1'b1);
      end
      chk("rnd_cnt", err_cnt, 8'h01);

      // Saturation: 260 failing zero-length frames back to back
      RST = 1'b0;
      tick();
      RST = 1'b1;
      for (int k = 1; k <= 260; k++) begin
         send_crc(8'h00, 8);
         if (k == 254) chk("sat_fe", err_cnt, 8'hFE);
         if (k == 255) chk("sat_ff", err_cnt, 8'hFF);
      end
      chk("sat_done", done, 1'b1);
      chk("sat_err", crc_err, 1'b1);
      chk("sat_hold", err_cnt, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
